// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with start/run/done control FSM
// Picks hold, +1, LUT jump or relative branch each RUN cycle; tracks run cycles and PC wrap.
module pc_sequencer #(
  parameter int unsigned D     = 12,
  parameter logic [D-1:0] START = '0,
  parameter int unsigned C     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump_en,
  input  logic [D-1:0] lut_target,
  input  logic         rel_en,
  input  logic [7:0]   rel_off,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         wrap_err,
  output logic [C-1:0] cycle_ct
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;
  logic         r_wrap;
  logic [C-1:0] r_ct;

  // Two extra bits above the PC: bit D flags carry, bit D+1 flags a negative (borrow) result.
  logic [D:0]   w_inc;
  logic [D+1:0] w_rel;
  logic         w_rel_wrap;
  logic         w_ct_sat;

  assign w_inc      = {1'b0, r_pc} + {{D{1'b0}}, 1'b1};
  assign w_rel      = {2'b00, r_pc} + {{(D-6){rel_off[7]}}, rel_off};
  assign w_rel_wrap = w_rel[D+1] | w_rel[D];
  assign w_ct_sat   = &r_ct;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pc      <= START;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_ct      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= RUN;
            r_pc      <= START;
            r_running <= 1'b1;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_ct      <= '0;
          end
        end
        RUN: begin
          if (!w_ct_sat) begin
            r_ct <= r_ct + {{(C-1){1'b0}}, 1'b1};
          end
          if (stall) begin
            r_pc <= r_pc;
          end else if (halt) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (jump_en) begin
            r_pc <= lut_target;
          end else if (rel_en) begin
            r_pc   <= w_rel[D-1:0];
            r_wrap <= r_wrap | w_rel_wrap;
          end else begin
            r_pc   <= w_inc[D-1:0];
            r_wrap <= r_wrap | w_inc[D];
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr = r_pc;
  assign running  = r_running;
  assign done     = r_done;
  assign wrap_err = r_wrap;
  assign cycle_ct = r_ct;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
// Stimulus queues hand-computed expectations; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        halt;
  logic        jump_en;
  logic [11:0] lut_target;
  logic        rel_en;
  logic [7:0]  rel_off;
  logic [11:0] prog_ctr;
  logic        running;
  logic        done;
  logic        wrap_err;
  logic [15:0] cycle_ct;

  typedef struct {
    logic [11:0] pc;
    logic        run;
    logic        dn;
    logic        wr;
    logic [15:0] ct;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;

  pc_sequencer #(.D(12), .START(12'h000), .C(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .halt       (halt),
    .jump_en    (jump_en),
    .lut_target (lut_target),
    .rel_en     (rel_en),
    .rel_off    (rel_off),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .wrap_err   (wrap_err),
    .cycle_ct   (cycle_ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 5;
      if (prog_ctr !== e.pc) begin
        n_fails++;
        $display("FAIL %s prog_ctr: got %h expected %h", e.name, prog_ctr, e.pc);
      end
      if (running !== e.run) begin
        n_fails++;
        $display("FAIL %s running: got %b expected %b", e.name, running, e.run);
      end
      if (done !== e.dn) begin
        n_fails++;
        $display("FAIL %s done: got %b expected %b", e.name, done, e.dn);
      end
      if (wrap_err !== e.wr) begin
        n_fails++;
        $display("FAIL %s wrap_err: got %b expected %b", e.name, wrap_err, e.wr);
      end
      if (cycle_ct !== e.ct) begin
        n_fails++;
        $display("FAIL %s cycle_ct: got %0d expected %0d", e.name, cycle_ct, e.ct);
      end
    end
  end

  // Apply one cycle of controls, then queue what the outputs must show after that edge.
  task automatic step(input logic rst_n, input logic st, input logic stl, input logic hlt,
                      input logic je, input logic [11:0] tgt, input logic re,
                      input logic [7:0] off, input logic [11:0] e_pc, input logic e_run,
                      input logic e_dn, input logic e_wr, input logic [15:0] e_ct,
                      input string name);
    exp_t e;
    reset      = rst_n;
    start      = st;
    stall      = stl;
    halt       = hlt;
    jump_en    = je;
    lut_target = tgt;
    rel_en     = re;
    rel_off    = off;
    @(posedge clk);
    #1;
    e.pc = e_pc; e.run = e_run; e.dn = e_dn; e.wr = e_wr; e.ct = e_ct; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    jump_en = 1'b0; lut_target = '0; rel_en = 1'b0; rel_off = '0;
    @(posedge clk);
    #1;
    //   rst st stl hlt je tgt      re off     pc       run dn wr ct
    step(0, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 0, 0, 0, 16'd0,  "reset0");
    step(0, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 0, 0, 0, 16'd0,  "reset1");
    step(1, 0, 0, 0, 1, 12'h123, 1, 8'h07, 12'h000, 0, 0, 0, 16'd0,  "idle_ignore");
    step(1, 1, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 1, 0, 0, 16'd0,  "start");
    step(1, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h001, 1, 0, 0, 16'd1,  "inc1");
    step(1, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h002, 1, 0, 0, 16'd2,  "inc2");
    step(1, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h003, 1, 0, 0, 16'd3,  "inc3");
    step(1, 0, 0, 0, 1, 12'h0A5, 1, 8'h05, 12'h0A5, 1, 0, 0, 16'd4,  "jump_over_rel");
    step(1, 0, 0, 0, 1, 12'h010, 0, 8'h00, 12'h010, 1, 0, 0, 16'd5,  "jump_010");
    step(1, 0, 0, 0, 0, 12'h000, 1, 8'hFC, 12'h00C, 1, 0, 0, 16'd6,  "rel_neg4");
    step(1, 0, 0, 0, 0, 12'h000, 1, 8'h05, 12'h011, 1, 0, 0, 16'd7,  "rel_pos5");
    step(1, 1, 0, 0, 0, 12'h000, 0, 8'h00, 12'h012, 1, 0, 0, 16'd8,  "start_in_run");
    step(1, 0, 0, 0, 1, 12'h005, 0, 8'h00, 12'h005, 1, 0, 0, 16'd9,  "jump_005");
    step(1, 0, 1, 1, 1, 12'h0FF, 1, 8'h01, 12'h005, 1, 0, 0, 16'd10, "stall1");
    step(1, 0, 1, 1, 0, 12'h000, 0, 8'h00, 12'h005, 1, 0, 0, 16'd11, "stall2");
    step(1, 0, 1, 1, 0, 12'h000, 0, 8'h00, 12'h005, 1, 0, 0, 16'd12, "stall3");
    step(1, 0, 0, 1, 1, 12'h0FF, 0, 8'h00, 12'h005, 0, 1, 0, 16'd13, "halt");
    step(1, 0, 0, 0, 1, 12'h0FF, 1, 8'h02, 12'h005, 0, 1, 0, 16'd13, "done_hold");
    step(1, 1, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 1, 0, 0, 16'd0,  "restart");
    step(1, 0, 0, 0, 1, 12'hFFF, 0, 8'h00, 12'hFFF, 1, 0, 0, 16'd1,  "jump_fff");
    step(1, 0, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 1, 0, 1, 16'd2,  "inc_wrap");
    step(1, 0, 0, 0, 0, 12'h000, 1, 8'hFF, 12'hFFF, 1, 0, 1, 16'd3,  "rel_borrow");
    step(0, 1, 0, 0, 1, 12'h0AA, 0, 8'h00, 12'h000, 0, 0, 0, 16'd0,  "reset_midrun");
    step(1, 1, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 1, 0, 0, 16'd0,  "start2");
    step(1, 0, 0, 0, 0, 12'h000, 1, 8'hFF, 12'hFFF, 1, 0, 1, 16'd1,  "borrow_from0");
    step(1, 0, 0, 0, 1, 12'h020, 0, 8'h00, 12'h020, 1, 0, 1, 16'd2,  "wrap_sticky");
    step(1, 0, 0, 1, 0, 12'h000, 0, 8'h00, 12'h020, 0, 1, 1, 16'd3,  "halt2");
    step(1, 1, 0, 0, 0, 12'h000, 0, 8'h00, 12'h000, 1, 0, 0, 16'd0,  "start_clears_wrap");
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
